// File: rtl/image_op_scheduler_pkg.sv
// Shared encodings for the image operation scheduler: operation codes,
// controller states and the operation-to-select decode.
package image_pkg;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_DEC  = 3'd2;
    localparam logic [2:0] OP_THR  = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTART,
        ST_RUN,
        ST_GAP
    } state_t;

    // Bit order matches {invert, threshold, decreaseBrightness, increaseBrightness}
    function automatic logic [3:0] op_onehot(input logic [2:0] op);
        case (op)
            OP_INC:  op_onehot = 4'b0001;
            OP_DEC:  op_onehot = 4'b0010;
            OP_THR:  op_onehot = 4'b0100;
            OP_INV:  op_onehot = 4'b1000;
            default: op_onehot = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/image_op_scheduler_button_debounce.sv
// Push-button debouncer: the level follows the raw input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive samples; rise_pulse marks a 0->1 change.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          rise_reg;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            if (raw_in == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_reg <= raw_in;
                rise_reg  <= raw_in;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level_out  = level_reg;
    assign rise_pulse = rise_reg;

endmodule

// File: rtl/image_op_scheduler.sv
// Frame-level controller for image_read: queues debounced button requests,
// grants one per frame round-robin and sequences reset/run/gap around each frame.
module image_op_scheduler
    import image_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int RESTART_LOW_CYCLES = 4,
    parameter int GAP_CYCLES         = 8,
    parameter int FRAME_TIMEOUT      = 65535,
    parameter int CNT_W              = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             btn_increase,
    input  logic             btn_decrease,
    input  logic             btn_threshold,
    input  logic             btn_invert,
    input  logic             auto_mode,
    input  logic             frame_done,
    output logic             read_resetn,
    output logic             increaseBrightness,
    output logic             decreaseBrightness,
    output logic             threshold,
    output logic             invert,
    output logic [2:0]       active_op,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic             timeout_err
);

    localparam int MAX_RG  = (GAP_CYCLES > RESTART_LOW_CYCLES) ? GAP_CYCLES : RESTART_LOW_CYCLES;
    localparam int TMR_MAX = (FRAME_TIMEOUT > MAX_RG) ? FRAME_TIMEOUT : MAX_RG;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [3:0] raw_vec, rise_vec, level_vec, set_vec;

    assign raw_vec = {btn_invert, btn_threshold, btn_decrease, btn_increase};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .HCLK       (HCLK),
                .HRESET     (HRESET),
                .raw_in     (raw_vec[gi]),
                .level_out  (level_vec[gi]),
                .rise_pulse (rise_vec[gi])
            );
        end
    endgenerate

    // A rise pulse is only ever issued together with the level going high
    assign set_vec = rise_vec & level_vec;

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   tmr_reg, tmr_next;
    logic [3:0]         pending_reg, pending_next;
    logic [1:0]         rr_reg, rr_next;
    logic [2:0]         op_reg, op_next;
    logic [3:0]         sel_reg, sel_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               terr_reg, terr_next;
    logic               read_resetn_reg;

    logic               grant_found;
    logic [1:0]         grant_idx, cand;

    // Scan downwards so the lowest offset from the pointer wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_reg;
        cand        = rr_reg;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_reg + 2'(i);
            if (pending_reg[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        tmr_next     = tmr_reg;
        pending_next = pending_reg | set_vec;
        rr_next      = rr_reg;
        op_next      = op_reg;
        sel_next     = sel_reg;
        cnt_next     = cnt_reg;
        terr_next    = terr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_found) begin
                    // New edge in the grant cycle re-queues the request
                    pending_next = (pending_reg & ~(4'b0001 << grant_idx)) | set_vec;
                    op_next      = {1'b0, grant_idx} + 3'd1;
                    rr_next      = grant_idx + 2'd1;
                    sel_next     = op_onehot({1'b0, grant_idx} + 3'd1);
                    state_next   = ST_RESTART;
                    tmr_next     = '0;
                end else if (auto_mode) begin
                    sel_next   = op_onehot(op_reg);
                    state_next = ST_RESTART;
                    tmr_next   = '0;
                end
            end
            ST_RESTART: begin
                if (tmr_reg == TMR_W'(RESTART_LOW_CYCLES - 1)) begin
                    state_next = ST_RUN;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_done) begin
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = ST_GAP;
                    tmr_next   = '0;
                end else if (tmr_reg == TMR_W'(FRAME_TIMEOUT - 1)) begin
                    terr_next  = 1'b1;
                    state_next = ST_GAP;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_reg == TMR_W'(GAP_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tmr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg       <= ST_IDLE;
            tmr_reg         <= '0;
            pending_reg     <= '0;
            rr_reg          <= '0;
            op_reg          <= OP_PASS;
            sel_reg         <= '0;
            cnt_reg         <= '0;
            terr_reg        <= 1'b0;
            read_resetn_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tmr_reg         <= tmr_next;
            pending_reg     <= pending_next;
            rr_reg          <= rr_next;
            op_reg          <= op_next;
            sel_reg         <= sel_next;
            cnt_reg         <= cnt_next;
            terr_reg        <= terr_next;
            read_resetn_reg <= (state_next == ST_RUN);
        end
    end

    assign read_resetn        = read_resetn_reg;
    assign increaseBrightness = sel_reg[0];
    assign decreaseBrightness = sel_reg[1];
    assign threshold          = sel_reg[2];
    assign invert             = sel_reg[3];
    assign active_op          = op_reg;
    assign busy               = (state_reg != ST_IDLE);
    assign frame_count        = cnt_reg;
    assign timeout_err        = terr_reg;

endmodule

// File: tb/tb_image_op_scheduler.sv
// Bench for image_op_scheduler: directed frame scenarios plus random buttons,
// all checked every cycle against a frame-level behavioural model.
module tb_image_op_scheduler;

    localparam int DEB   = 16;
    localparam int RL    = 4;
    localparam int GAP   = 8;
    localparam int TMO   = 100;
    localparam int CNT_W = 4;

    logic HCLK, HRESET;
    logic btn_increase, btn_decrease, btn_threshold, btn_invert;
    logic auto_mode, frame_done, man_done, rnd_done;
    logic read_resetn, increaseBrightness, decreaseBrightness, threshold, invert;
    logic [2:0] active_op;
    logic busy, timeout_err;
    logic [CNT_W-1:0] frame_count;

    int n_err = 0;
    int n_checks = 0;
    bit chk_en = 0;
    bit resp_en = 0;
    bit noise_en = 0;

    assign frame_done = man_done | rnd_done;

    image_op_scheduler #(
        .DEBOUNCE_CYCLES(DEB), .RESTART_LOW_CYCLES(RL), .GAP_CYCLES(GAP),
        .FRAME_TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .btn_increase(btn_increase), .btn_decrease(btn_decrease),
        .btn_threshold(btn_threshold), .btn_invert(btn_invert),
        .auto_mode(auto_mode), .frame_done(frame_done),
        .read_resetn(read_resetn),
        .increaseBrightness(increaseBrightness), .decreaseBrightness(decreaseBrightness),
        .threshold(threshold), .invert(invert),
        .active_op(active_op), .busy(busy),
        .frame_count(frame_count), .timeout_err(timeout_err)
    );

    initial HCLK = 0;
    always #5 HCLK = ~HCLK;

    // Frame-level model: phase 0 idle, 1 restart, 2 run, 3 gap
    int m_ph, m_left, m_runc, m_op, m_rr, m_cnt;
    bit m_terr;
    bit [3:0] m_pend, m_rise, m_level;
    int m_run [4];

    always @(posedge HCLK) begin
        bit [3:0] raw, rise_old, gmask;
        bit found;
        int k;
        raw = {btn_invert, btn_threshold, btn_decrease, btn_increase};
        if (HRESET) begin
            m_ph = 0; m_left = 0; m_runc = 0; m_op = 0; m_rr = 0; m_cnt = 0;
            m_terr = 0; m_pend = 0; m_rise = 0; m_level = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            rise_old = m_rise;
            gmask = 0;
            found = 0;
            case (m_ph)
                0: begin
                    for (int i = 0; i < 4; i++) begin
                        k = (m_rr + i) % 4;
                        if (!found && m_pend[k]) begin
                            found = 1;
                            gmask[k] = 1;
                            m_op = k + 1;
                            m_rr = (k + 1) % 4;
                        end
                    end
                    if (found || auto_mode) begin
                        m_ph = 1;
                        m_left = RL;
                    end
                end
                1: if (m_left == 1) begin m_ph = 2; m_runc = 0; end else m_left--;
                2: begin
                    m_runc++;
                    if (frame_done) begin
                        m_cnt = (m_cnt + 1) % (1 << CNT_W);
                        m_ph = 3; m_left = GAP;
                    end else if (m_runc == TMO) begin
                        m_terr = 1;
                        m_ph = 3; m_left = GAP;
                    end
                end
                default: if (m_left == 1) m_ph = 0; else m_left--;
            endcase
            m_pend = (m_pend & ~gmask) | rise_old;
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = 0;
                if (raw[i] == m_level[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_level[i] = raw[i];
                        m_rise[i] = raw[i];
                        m_run[i] = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge HCLK) begin
        logic [3:0] exp_sel;
        logic [13:0] exp_v, act_v;
        if (chk_en) begin
            exp_sel = (m_op == 0) ? 4'b0000 : (4'b0001 << (m_op - 1));
            exp_v = {(m_ph == 2), exp_sel, 3'(m_op), (m_ph != 0), CNT_W'(m_cnt), m_terr};
            act_v = {read_resetn, invert, threshold, decreaseBrightness, increaseBrightness,
                     active_op, busy, frame_count, timeout_err};
            n_checks++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle t=%0t: got rstn/sel/op/busy/cnt/terr=%b expected %b",
                         $time, act_v, exp_v);
            end
        end
    end

    // Frame responder: random done pulses in RUN, optional stray pulses elsewhere
    always @(posedge HCLK) begin
        #2;
        rnd_done = 0;
        if (resp_en && read_resetn === 1'b1) rnd_done = ($urandom_range(0, 3) == 0);
        else if (noise_en) rnd_done = ($urandom_range(0, 9) == 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_rstn(input logic v, input int limit, input string name);
        int k = 0;
        while (read_resetn !== v && k < limit) begin step(1); k++; end
        chk(name, 32'(read_resetn), 32'(v));
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < limit) begin step(1); k++; end
        chk(name, 32'(busy), 0);
    endtask

    task automatic press(input logic [3:0] b, input int n);
        {btn_invert, btn_threshold, btn_decrease, btn_increase} = b;
        step(n);
        {btn_invert, btn_threshold, btn_decrease, btn_increase} = 4'b0000;
    endtask

    task automatic do_reset();
        HRESET = 1;
        step(2);
        HRESET = 0;
    endtask

    initial begin
        int k;
        HRESET = 1; auto_mode = 0; man_done = 0; rnd_done = 0;
        {btn_invert, btn_threshold, btn_decrease, btn_increase} = 4'b0000;
        step(1);
        chk_en = 1;
        step(2);
        chk("reset_rstn", 32'(read_resetn), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(frame_count), 0);
        chk("reset_terr", 32'(timeout_err), 0);
        chk("reset_op", 32'(active_op), 0);
        HRESET = 0;

        // Threshold request: RUN begins 22 edges after the button goes high
        btn_threshold = 1;
        step(20);
        btn_threshold = 0;
        step(1);
        chk("thr_restart_busy", 32'(busy), 1);
        chk("thr_restart_rstn", 32'(read_resetn), 0);
        step(1);
        chk("thr_run_rstn", 32'(read_resetn), 1);
        chk("thr_sel", 32'(threshold), 1);
        chk("thr_op", 32'(active_op), 3);
        man_done = 1;
        step(1);
        man_done = 0;
        chk("thr_count", 32'(frame_count), 1);
        chk("thr_gap_rstn", 32'(read_resetn), 0);
        step(7);
        chk("thr_gap_busy", 32'(busy), 1);
        step(1);
        chk("thr_idle_busy", 32'(busy), 0);

        // Bouncing invert button never settles long enough
        for (int i = 0; i < 12; i++) begin
            btn_invert = ~btn_invert;
            step(5);
            chk("bounce_busy", 32'(busy), 0);
        end
        btn_invert = 0;
        step(30);
        chk("bounce_final", 32'(busy), 0);

        // Round-robin from a fresh pointer
        do_reset();
        resp_en = 1;
        press(4'b1011, 20);
        wait_rstn(1, 100, "rr1_run");  chk("rr1_op", 32'(active_op), 1);
        wait_rstn(0, 200, "rr1_end");
        wait_rstn(1, 100, "rr2_run");  chk("rr2_op", 32'(active_op), 2);
        wait_rstn(0, 200, "rr2_end");
        wait_rstn(1, 100, "rr3_run");  chk("rr3_op", 32'(active_op), 4);
        wait_idle(200, "rr3_idle");
        press(4'b0011, 20);
        wait_rstn(1, 100, "rr4_run");  chk("rr4_op_ptr0", 32'(active_op), 1);
        wait_rstn(0, 200, "rr4_end");
        wait_rstn(1, 100, "rr5_run");  chk("rr5_op", 32'(active_op), 2);
        wait_idle(200, "rr5_idle");

        // Timeout: no frame_done for TMO cycles
        resp_en = 0;
        press(4'b0001, 20);
        wait_rstn(1, 100, "tmo_run");
        step(TMO - 1);
        chk("tmo_pre_terr", 32'(timeout_err), 0);
        chk("tmo_pre_rstn", 32'(read_resetn), 1);
        step(1);
        chk("tmo_terr", 32'(timeout_err), 1);
        chk("tmo_rstn", 32'(read_resetn), 0);
        chk("tmo_count", 32'(frame_count), 5);
        step(GAP);
        chk("tmo_idle", 32'(busy), 0);
        man_done = 1;
        step(1);
        man_done = 0;
        step(2);
        chk("tmo_sticky", 32'(timeout_err), 1);
        chk("tmo_done_ignored", 32'(frame_count), 5);

        // Auto mode repeats INV; count wraps at 2^CNT_W
        do_reset();
        resp_en = 1;
        press(4'b1000, 20);
        wait_rstn(1, 100, "auto_run");
        auto_mode = 1;
        k = 0;
        while (frame_count !== 4'd3 && k < 500) begin step(1); k++; end
        chk("auto_count3", 32'(frame_count), 3);
        chk("auto_invert", 32'(invert), 1);
        k = 0;
        while (frame_count !== 4'd15 && k < 1000) begin step(1); k++; end
        chk("auto_count15", 32'(frame_count), 15);
        k = 0;
        while (frame_count === 4'd15 && k < 200) begin step(1); k++; end
        chk("auto_wrap", 32'(frame_count), 0);

        // Reset in the middle of a frame
        wait_rstn(1, 100, "mid_run");
        HRESET = 1;
        step(1);
        chk("mid_rstn", 32'(read_resetn), 0);
        chk("mid_sel", 32'({invert, threshold, decreaseBrightness, increaseBrightness}), 0);
        chk("mid_count", 32'(frame_count), 0);
        chk("mid_busy", 32'(busy), 0);
        HRESET = 0; auto_mode = 0; resp_en = 0;
        man_done = 1;
        step(1);
        man_done = 0;
        step(20);
        chk("mid_after_count", 32'(frame_count), 0);
        chk("mid_after_busy", 32'(busy), 0);

        // Random buttons, auto mode and stray done pulses against the model
        resp_en = 1; noise_en = 1;
        for (int i = 0; i < 150; i++) begin
            {btn_invert, btn_threshold, btn_decrease, btn_increase} = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) auto_mode = ~auto_mode;
            step($urandom_range(1, 30));
        end
        {btn_invert, btn_threshold, btn_decrease, btn_increase} = 4'b0000;
        auto_mode = 0; noise_en = 0;
        step(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
